// File: rtl/packet_transmitter.sv
// packet_transmitter
//   Serialises one response request into a framed packet for the UART core:
//     SYNC, LEN (= nargs+1), OPCODE, ARG[0..nargs-1], CRC
//   CRC is CRC-8 (poly 0x07, init 0x00, MSB-first, no final XOR) over
//   LEN, OPCODE and ARGs. SYNC is not covered.
//
// Ports
//   CLK, rst      clock; synchronous active-high reset
//   req_valid     request present
//   req_ready     high only while idle; request taken on req_valid && req_ready
//   req_opcode    opcode byte
//   req_nargs     number of argument bytes (0..MAX_ARGS)
//   req_args      argument i at [8*i +: 8]
//   tx_data       byte to the UART core
//   tx_valid      tx_data valid
//   tx_ready      UART core can take a byte
//   frame_done    one-cycle pulse after the CRC byte is taken
//   err_len       one-cycle pulse when an over-length request is dropped
module packet_transmitter #(
  parameter logic [7:0] SYNC     = 8'hAA,
  parameter int         MAX_ARGS = 8,
  parameter int         NW       = $clog2(MAX_ARGS + 1)
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_opcode,
  input  logic [NW-1:0]         req_nargs,
  input  logic [8*MAX_ARGS-1:0] req_args,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  frame_done,
  output logic                  err_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LEN,
    S_OP,
    S_ARGS,
    S_CRC
  } state_t;

  localparam logic [NW-1:0] MAX_N = NW'(MAX_ARGS);

  state_t                state_q, state_d;
  logic [7:0]            opcode_q, opcode_d;
  logic [NW-1:0]         nargs_q, nargs_d;
  logic [NW-1:0]         idx_q, idx_d;
  logic [8*MAX_ARGS-1:0] args_q, args_d;
  logic [7:0]            crc_q, crc_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_len_q, err_len_d;

  logic                  xfer;
  logic [7:0]            arg_byte;
  logic [7:0]            len_byte;

  // One full byte through the CRC-8/0x07 shift register.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  assign tx_valid   = (state_q != S_IDLE);
  assign req_ready  = (state_q == S_IDLE);
  assign xfer       = tx_valid && tx_ready;
  assign frame_done = frame_done_q;
  assign err_len    = err_len_q;
  assign len_byte   = 8'(nargs_q) + 8'd1;

  // Explicit compare-mux avoids indexing past MAX_ARGS when NW has spare codes.
  always_comb begin
    arg_byte = 8'h00;
    for (int i = 0; i < MAX_ARGS; i++) begin
      if (idx_q == NW'(i)) begin
        arg_byte = args_q[8*i +: 8];
      end
    end
  end

  // Every byte comes from registers, so it stays stable until its handshake.
  always_comb begin
    case (state_q)
      S_SYNC:  tx_data = SYNC;
      S_LEN:   tx_data = len_byte;
      S_OP:    tx_data = opcode_q;
      S_ARGS:  tx_data = arg_byte;
      S_CRC:   tx_data = crc_q;
      default: tx_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    nargs_d      = nargs_q;
    idx_d        = idx_q;
    args_d       = args_q;
    crc_d        = crc_q;
    frame_done_d = 1'b0;
    err_len_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_nargs > MAX_N) begin
            err_len_d = 1'b1;
          end else begin
            opcode_d = req_opcode;
            nargs_d  = req_nargs;
            args_d   = req_args;
            crc_d    = 8'h00;
            idx_d    = '0;
            state_d  = S_SYNC;
          end
        end
      end
      S_SYNC: begin
        if (xfer) state_d = S_LEN;
      end
      S_LEN: begin
        if (xfer) begin
          crc_d   = crc8_step(crc_q, len_byte);
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (xfer) begin
          crc_d   = crc8_step(crc_q, opcode_q);
          state_d = (nargs_q == '0) ? S_CRC : S_ARGS;
        end
      end
      S_ARGS: begin
        if (xfer) begin
          crc_d = crc8_step(crc_q, arg_byte);
          if (idx_q == nargs_q - NW'(1)) begin
            state_d = S_CRC;
          end else begin
            idx_d = idx_q + NW'(1);
          end
        end
      end
      S_CRC: begin
        if (xfer) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= S_IDLE;
      opcode_q     <= 8'h00;
      nargs_q      <= '0;
      idx_q        <= '0;
      args_q       <= '0;
      crc_q        <= 8'h00;
      frame_done_q <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      nargs_q      <= nargs_d;
      idx_q        <= idx_d;
      args_q       <= args_d;
      crc_q        <= crc_d;
      frame_done_q <= frame_done_d;
      err_len_q    <= err_len_d;
    end
  end

endmodule

// File: tb/tb_packet_transmitter.sv
// Directed bench for packet_transmitter: reset values, minimal frame, random
// back-pressure, full-length frame, over-length drop, back-to-back requests
// with mid-frame input changes, and reset in the middle of a frame.
module tb_packet_transmitter;

  localparam int MAX_ARGS = 8;
  localparam int NW       = $clog2(MAX_ARGS + 1);

  logic                  CLK = 1'b0;
  logic                  rst;
  logic                  req_valid;
  logic                  req_ready;
  logic [7:0]            req_opcode;
  logic [NW-1:0]         req_nargs;
  logic [8*MAX_ARGS-1:0] req_args;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  frame_done;
  logic                  err_len;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] f1_bytes[4];
  int         cyc;

  packet_transmitter #(
    .SYNC     (8'hAA),
    .MAX_ARGS (MAX_ARGS),
    .NW       (NW)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_nargs  (req_nargs),
    .req_args   (req_args),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .frame_done (frame_done),
    .err_len    (err_len)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected frame built bit-serially: feedback = crc msb xor message bit.
  task automatic build_frame(input logic [7:0] op, input int n, input logic [8*MAX_ARGS-1:0] args);
    logic [7:0] body[$];
    logic [7:0] crc;
    logic [7:0] b;
    logic       fb;
    exp_q.delete();
    body.delete();
    body.push_back(8'(n + 1));
    body.push_back(op);
    for (int i = 0; i < n; i++) body.push_back(args[8*i +: 8]);
    crc = 8'h00;
    foreach (body[i]) begin
      b = body[i];
      for (int j = 7; j >= 0; j--) begin
        fb  = crc[7] ^ b[j];
        crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    exp_q.push_back(8'hAA);
    foreach (body[i]) exp_q.push_back(body[i]);
    exp_q.push_back(crc);
  endtask

  // Starts in the SYNC cycle; returns in the cycle where frame_done is expected.
  task automatic collect_frame(input bit rnd, input string tag, output int cycles);
    int  k;
    int  sz;
    bit  done;
    k      = 0;
    done   = 0;
    cycles = 0;
    sz     = int'(exp_q.size());
    while (!done && cycles < 400) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid) begin
        if (k < sz) chk({tag, "_byte"}, 32'(tx_data), 32'(exp_q[k]));
        else        chk({tag, "_extra_byte"}, 32'(k), 32'(sz));
        chk({tag, "_early_done"}, 32'(frame_done), 32'd0);
        if (tx_ready) k++;
      end else begin
        chk({tag, "_valid_dropped"}, 32'(tx_valid), 32'd1);
      end
      step();
      cycles++;
      if (k == sz) begin
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd1);
        chk({tag, "_idle_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        done = 1;
      end
    end
    chk({tag, "_bytes_sent"}, 32'(k), 32'(sz));
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_opcode = 8'h00;
    req_nargs  = '0;
    req_args   = '0;
    tx_ready   = 1'b0;
    step();
    step();

    chk("rst_tx_valid",   32'(tx_valid),   32'd0);
    chk("rst_tx_data",    32'(tx_data),    32'h00);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err_len",    32'(err_len),    32'd0);
    chk("rst_req_ready",  32'(req_ready),  32'd1);

    rst      = 1'b0;
    tx_ready = 1'b1;
    repeat (3) begin
      step();
      chk("idle_no_req_valid", 32'(tx_valid), 32'd0);
    end

    // Minimal frame: AA 01 10 65, no bubbles.
    f1_bytes[0] = 8'hAA;
    f1_bytes[1] = 8'h01;
    f1_bytes[2] = 8'h10;
    f1_bytes[3] = 8'h65;
    req_opcode = 8'h10;
    req_nargs  = '0;
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("f1_valid", 32'(tx_valid), 32'd1);
      chk("f1_byte",  32'(tx_data),  32'(f1_bytes[i]));
      step();
    end
    chk("f1_frame_done", 32'(frame_done), 32'd1);
    chk("f1_req_ready",  32'(req_ready),  32'd1);
    chk("f1_idle_valid", 32'(tx_valid),   32'd0);
    step();
    chk("f1_done_pulse", 32'(frame_done), 32'd0);

    // Two args under random back-pressure.
    req_opcode       = 8'h02;
    req_nargs        = NW'(2);
    req_args         = '0;
    req_args[7:0]    = 8'h33;
    req_args[15:8]   = 8'h44;
    build_frame(8'h02, 2, req_args);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    collect_frame(1'b1, "f2", cyc);

    // Full-length frame, args 00..07.
    tx_ready   = 1'b1;
    req_opcode = 8'h7E;
    req_nargs  = NW'(MAX_ARGS);
    for (int i = 0; i < MAX_ARGS; i++) req_args[8*i +: 8] = 8'(i);
    build_frame(8'h7E, MAX_ARGS, req_args);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    collect_frame(1'b0, "fmax", cyc);
    chk("fmax_cycles", 32'(cyc), 32'(MAX_ARGS + 4));

    // Over-length request dropped.
    step();
    req_nargs = NW'(MAX_ARGS + 1);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("ovl_err_len",   32'(err_len),   32'd1);
    chk("ovl_tx_valid",  32'(tx_valid),  32'd0);
    chk("ovl_req_ready", 32'(req_ready), 32'd1);
    step();
    chk("ovl_err_pulse", 32'(err_len),   32'd0);
    chk("ovl_tx_valid2", 32'(tx_valid),  32'd0);

    // Back-to-back with req_valid held; inputs change mid-frame.
    tx_ready       = 1'b1;
    req_opcode     = 8'h20;
    req_nargs      = NW'(1);
    req_args       = '0;
    req_args[7:0]  = 8'h5A;
    build_frame(8'h20, 1, req_args);
    req_valid = 1'b1;
    step();
    req_opcode     = 8'h21;
    req_nargs      = NW'(2);
    req_args[7:0]  = 8'h11;
    req_args[15:8] = 8'h22;
    collect_frame(1'b0, "b2b1", cyc);
    chk("b2b1_cycles", 32'(cyc), 32'd5);
    build_frame(8'h21, 2, req_args);
    step();
    req_valid = 1'b0;
    chk("b2b2_sync_valid", 32'(tx_valid), 32'd1);
    chk("b2b2_sync_data",  32'(tx_data),  32'hAA);
    collect_frame(1'b0, "b2b2", cyc);
    repeat (3) begin
      step();
      chk("b2b_no_dup", 32'(tx_valid), 32'd0);
    end

    // Reset while ARG[1] is on the bus.
    tx_ready       = 1'b1;
    req_opcode     = 8'h30;
    req_nargs      = NW'(3);
    req_args       = '0;
    req_args[7:0]  = 8'hA1;
    req_args[15:8] = 8'hB2;
    req_args[23:16]= 8'hC3;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    chk("mid_arg1", 32'(tx_data), 32'hB2);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(tx_valid),   32'd0);
    chk("mid_rst_ready", 32'(req_ready),  32'd1);
    chk("mid_rst_done",  32'(frame_done), 32'd0);
    chk("mid_rst_data",  32'(tx_data),    32'h00);
    rst = 1'b0;
    step();
    chk("post_rst_done",  32'(frame_done), 32'd0);
    chk("post_rst_valid", 32'(tx_valid),   32'd0);

    req_opcode    = 8'h31;
    req_nargs     = NW'(1);
    req_args      = '0;
    req_args[7:0] = 8'h99;
    build_frame(8'h31, 1, req_args);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    collect_frame(1'b1, "post_rst", cyc);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
